// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: interrupt-acknowledge engine sitting between the PIC and
// the CPU core. Generates the INTA_n pulse train, samples the PIC data bus on
// the last low cycle of the data pulses and presents the vector on a
// valid/ready handshake.
// Build option: define INTA_8080_MODE_EN to compile in the three-pulse 8080
// sequence and vec_addr_hi capture; otherwise only 8086 two-pulse sequences.
module pic_inta_sequencer #(
   parameter int unsigned PULSE_LEN = 2,
   parameter int unsigned GAP_LEN   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       int_in,
   input  logic       cpu_int_en,
   input  logic       mode_8086,
   input  logic [7:0] pic_data,
   input  logic       pic_data_io,
   output logic       inta_n,
   output logic       vec_valid,
   output logic [7:0] vec_data,
   output logic [7:0] vec_addr_hi,
   input  logic       vec_ready,
   output logic       busy,
   output logic       spurious
);

   localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int unsigned CW      = $clog2(MAX_LEN) + 1;
`ifdef INTA_8080_MODE_EN
   localparam int unsigned PW      = 2;
`else
   localparam int unsigned PW      = 1;
`endif
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);

   typedef enum logic [1:0] {IDLE, LOW, GAP, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [PW-1:0] pidx, pidx_nxt;
   logic          mode_q, mode_nxt;
   logic [7:0]    byte_q, byte_nxt;
   logic          inta_nxt, valid_nxt, busy_nxt, spur_nxt;
   logic [7:0]    data_nxt, hi_nxt;
   logic          start_mode;
   logic          final_pidx;

`ifdef INTA_8080_MODE_EN
   assign start_mode = mode_8086;
   assign final_pidx = mode_q ? (pidx == PW'(1)) : (pidx == PW'(2));
`else
   logic unused_mode;
   assign unused_mode = mode_8086;
   assign start_mode  = 1'b1;
   assign final_pidx  = (pidx == PW'(1));
`endif

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pidx        <= '0;
         mode_q      <= 1'b1;
         byte_q      <= '0;
         inta_n      <= 1'b1;
         vec_valid   <= 1'b0;
         vec_data    <= '0;
         vec_addr_hi <= '0;
         busy        <= 1'b0;
         spurious    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         pidx        <= pidx_nxt;
         mode_q      <= mode_nxt;
         byte_q      <= byte_nxt;
         inta_n      <= inta_nxt;
         vec_valid   <= valid_nxt;
         vec_data    <= data_nxt;
         vec_addr_hi <= hi_nxt;
         busy        <= busy_nxt;
         spurious    <= spur_nxt;
      end
   end

   // Next-state and next-output logic.
   // inta_n is registered from the current state, so it lags the LOW state by
   // one cycle; the last low cycle of a pulse therefore coincides with the
   // first cycle of the following GAP/HOLD state, which is where data is sampled.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pidx_nxt  = pidx;
      mode_nxt  = mode_q;
      byte_nxt  = byte_q;
      inta_nxt  = (state != LOW);
      valid_nxt = vec_valid;
      busy_nxt  = busy;
      spur_nxt  = 1'b0;
      data_nxt  = vec_data;
      hi_nxt    = vec_addr_hi;
      case (state)
         IDLE: begin
            if (int_in && cpu_int_en) begin
               state_nxt = LOW;
               cnt_nxt   = '0;
               pidx_nxt  = '0;
               mode_nxt  = start_mode;
               busy_nxt  = 1'b1;
            end
         end
         LOW: begin
            if (cnt == PULSE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = final_pidx ? HOLD : GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            // Pulse-1 byte of an 8080 sequence is staged until the final
            // pulse proves the PIC is really driving the bus.
            if (cnt == '0 && pidx == PW'(1)) begin
               byte_nxt = pic_data;
            end
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
               pidx_nxt  = pidx + 1'b1;
               state_nxt = LOW;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HOLD: begin
            if (!vec_valid) begin
               if (pic_data_io) begin
                  spur_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  valid_nxt = 1'b1;
                  data_nxt  = mode_q ? pic_data : byte_q;
`ifdef INTA_8080_MODE_EN
                  hi_nxt    = mode_q ? 8'h00 : pic_data;
`else
                  hi_nxt    = 8'h00;
`endif
               end
            end else if (vec_ready) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

- CPU-side interrupt acknowledge engine placed directly downstream of the PIC.
- Watches the PIC `INT` output and generates the `INTA_n` pulse train: two pulses in 8086 mode, three in 8080 mode.
- Samples the PIC data bus during the final pulse(s).
- Hands the resulting vector to the CPU core over a valid/ready handshake.

## Interface

Parameters:
- PULSE_LEN, 2, cycles `inta_n` is held low per pulse (≥1)
- GAP_LEN, 2, cycles `inta_n` is held high between pulses (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  active-low, asynchronous reset
- int_in  in  1  PIC `INT` output
- cpu_int_en  in  1  CPU interrupt-enable flag; new sequences start only when 1
- mode_8086  in  1  1 = two-pulse 8086 sequence, 0 = three-pulse 8080 sequence
- pic_data  in  8  PIC `data_out`
- pic_data_io  in  1  PIC `data_io`; 0 = PIC is driving `pic_data`
- inta_n  out  1  acknowledge strobe to the PIC, active low
- vec_valid  out  1  vector available to the CPU
- vec_data  out  8  8086 vector byte, or 8080 call address low byte
- vec_addr_hi  out  8  8080 call address high byte; 0 in 8086 mode
- vec_ready  in  1  CPU accepts the vector
- busy  out  1  a sequence is in progress or a vector is held
- spurious  out  1  one-cycle pulse: PIC did not drive the bus on the final pulse

## Operation

- All outputs are registered.
- Reset values: inta_n=1, vec_valid=0, vec_data=0, vec_addr_hi=0, busy=0, spurious=0, state=IDLE.
- FSM states: IDLE, LOW, GAP, HOLD. A pulse index `pidx` (0..2) and a cycle counter `cnt` (width ≥ clog2(max(PULSE_LEN, GAP_LEN))+1) qualify LOW and GAP.
- IDLE:
  - Start condition: int_in=1 and cpu_int_en=1.
  - On start: latch mode_8086 into `mode_q`, set pidx=0, cnt=0, go to LOW, set busy=1.
- LOW:
  - inta_n=0; cnt increments each cycle.
  - On the last cycle (cnt=PULSE_LEN-1), sample `pic_data`/`pic_data_io` per the capture rules below.
  - After that cycle: if this was the final pulse (pidx=1 in 8086 mode, pidx=2 in 8080 mode), go to HOLD, or to IDLE if spurious. Otherwise go to GAP.
- GAP:
  - inta_n=1 for GAP_LEN cycles.
  - Then pidx increments and the FSM returns to LOW.
- Capture rules:
  - 8086 mode: pulse 0 data is ignored; pulse 1 loads `vec_data`; vec_addr_hi=0.
  - 8080 mode: pulse 0 (CALL opcode) is ignored; pulse 1 loads `vec_data`; pulse 2 loads `vec_addr_hi`.
- Spurious: if pic_data_io=1 on the final-pulse sample:
  - spurious=1 for one cycle; vec_valid stays 0; the FSM returns to IDLE.
  - `vec_data`/`vec_addr_hi` keep their previous values.
- HOLD:
  - vec_valid=1; vector outputs are stable.
  - On vec_valid & vec_ready: vec_valid=0, busy=0, go to IDLE.
- Once a sequence starts, int_in and cpu_int_en are ignored until IDLE. A drop of int_in mid-sequence does not abort it.
- mode_8086 changes after start have no effect on the current sequence.
- Reset asserted in any state forces the reset values immediately (asynchronously). inta_n rises without completing the pulse.

## Timing

- Start condition sampled at edge k: inta_n falls after edge k+1 (one-cycle registered latency).
- Pulse n (0-based) low window starts at k+1+n·(PULSE_LEN+GAP_LEN) and lasts PULSE_LEN cycles.
- After the final low window: inta_n rises and vec_valid (or spurious) asserts on the same edge.
- Total cycles from start to vec_valid:
  - 8086: 2·PULSE_LEN+GAP_LEN+1
  - 8080: 3·PULSE_LEN+2·GAP_LEN+1
- Handshake:
  - Transfer occurs on any edge with vec_valid=1 and vec_ready=1.
  - vec_ready may be held high in advance; the transfer then occurs on the first vec_valid edge.
  - After a transfer, IDLE is occupied for at least one cycle. The earliest next inta_n fall is two edges after the transfer.
- Sample point: the last low cycle of each pulse, so the PIC's combinational data_out has PULSE_LEN-1 cycles to settle.

## Configuration

- INTA_8080_MODE_EN defined:
  - Three-pulse 8080 path compiled in; mode_8086 is honored; vec_addr_hi is captured.
- Undefined:
  - mode_8086 is ignored (treated as 1); only two-pulse sequences are generated.
  - vec_addr_hi is tied to 0; pidx reduces to 1 bit.

## Test plan

Default parameters (PULSE_LEN=2, GAP_LEN=2). Cycle numbers are counted from the start edge k.

- 8086 vector: int_in=1, cpu_int_en=1, mode_8086=1, PIC drives 0x48 on pulse 1 -> inta_n low cycles 1–2 and 5–6; vec_valid=1 at cycle 7; vec_data=0x48, vec_addr_hi=0x00.
- 8080 vector (macro defined): mode_8086=0, bytes 0xCD/0x20/0x00 -> three low windows (1–2, 5–6, 9–10); vec_valid at 11; vec_data=0x20, vec_addr_hi=0x00.
- Spurious: pic_data_io=1 during pulse 1 in 8086 mode -> spurious=1 for exactly cycle 7; vec_valid stays 0; FSM back in IDLE; vec_data unchanged.
- Backpressure: vec_ready=0 for 5 cycles after vec_valid, int_in held 1 -> no further inta_n pulses; vec_data stable; transfer on the first vec_ready=1 edge; next sequence's inta_n falls 2 edges later.
- Gating: int_in=1 with cpu_int_en=0 for 10 cycles -> inta_n stays 1, busy=0; raise cpu_int_en -> inta_n falls one cycle later.
- Reset mid-pulse: assert reset during the second low window -> inta_n=1 and busy=0 immediately, without waiting for a clock edge; after release, the FSM is in IDLE and a full sequence runs normally.
